// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU / address generation, serial shifter and an
// optional shift-add multiplier (enabled by defining EX_STAGE_MUL_EN).
module ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  op,
    input  logic [15:0] rs_val,
    input  logic [15:0] rt_val,
    input  logic [15:0] imm,
    input  logic [15:0] st_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic [15:0] rd,
    output logic        mem_w
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_MUL = 4'd7;
    localparam logic [3:0] OP_LD  = 4'd8;
    localparam logic [3:0] OP_ST  = 4'd9;

    state_e      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] work_q, work_d;
    logic [15:0] result_q, result_d;
    logic [15:0] rd_q, rd_d;
    logic        mem_w_q, mem_w_d;
    logic        out_valid_q, out_valid_d;
`ifdef EX_STAGE_MUL_EN
    logic [15:0] mcand_q, mcand_d;
    logic [15:0] mplier_q, mplier_d;
`endif

    logic        accept;
    logic        fin;
    logic [15:0] fin_val;
    logic        fin_st;

    // Everything that completes in the acceptance cycle; reserved ops give 0.
    function automatic logic [15:0] alu(input logic [3:0] o, input logic [15:0] a,
                                        input logic [15:0] b, input logic [15:0] i);
        logic [15:0] r;
        case (o)
            OP_ADD:       r = a + b;
            OP_SUB:       r = a - b;
            OP_AND:       r = a & b;
            OP_OR:        r = a | b;
            OP_XOR:       r = a ^ b;
            OP_LD, OP_ST: r = a + i;
            default:      r = 16'h0000;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        work_d      = work_q;
        result_d    = result_q;
        rd_d        = rd_q;
        mem_w_d     = mem_w_q;
        out_valid_d = out_valid_q;
`ifdef EX_STAGE_MUL_EN
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
`endif
        fin         = 1'b0;
        fin_val     = 16'h0000;
        fin_st      = 1'b0;

        in_ready = rst_n && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
        accept   = in_valid && in_ready;

        if (state_q == BUSY) begin
            cnt_d = cnt_q - 5'd1;
            case (op_q)
                OP_SLL: work_d = work_q << 1;
                OP_SRL: work_d = work_q >> 1;
`ifdef EX_STAGE_MUL_EN
                OP_MUL: begin
                    work_d   = work_q + (mplier_q[0] ? mcand_q : 16'h0000);
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                end
`endif
                default: work_d = work_q;
            endcase
            if (cnt_q == 5'd1) begin
                fin     = 1'b1;
                fin_val = work_d;
            end
        end else if (accept) begin
            op_d   = op;
            rd_d   = (op == OP_ST) ? st_data : rs_val;
            work_d = rs_val;
            cnt_d  = 5'd0;
            case (op)
                OP_SLL, OP_SRL: begin
                    if (rt_val[3:0] == 4'd0) begin
                        fin     = 1'b1;
                        fin_val = rs_val;
                    end else begin
                        cnt_d = {1'b0, rt_val[3:0]};
                    end
                end
`ifdef EX_STAGE_MUL_EN
                OP_MUL: begin
                    cnt_d    = 5'd16;
                    work_d   = 16'h0000;
                    mcand_d  = rs_val;
                    mplier_d = rt_val;
                end
`endif
                default: begin
                    fin     = 1'b1;
                    fin_val = alu(op, rs_val, rt_val, imm);
                    fin_st  = (op == OP_ST);
                end
            endcase
            if (!fin) begin
                state_d     = BUSY;
                out_valid_d = 1'b0;
                mem_w_d     = 1'b0;
            end
        end else if ((state_q == DONE) && out_ready) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            mem_w_d     = 1'b0;
        end

        if (fin) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            result_d    = fin_val;
            mem_w_d     = fin_st;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= 4'd0;
            cnt_q       <= 5'd0;
            work_q      <= 16'h0000;
            result_q    <= 16'h0000;
            rd_q        <= 16'h0000;
            mem_w_q     <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef EX_STAGE_MUL_EN
            mcand_q     <= 16'h0000;
            mplier_q    <= 16'h0000;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            work_q      <= work_d;
            result_q    <= result_d;
            rd_q        <= rd_d;
            mem_w_q     <= mem_w_d;
            out_valid_q <= out_valid_d;
`ifdef EX_STAGE_MUL_EN
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign rd        = rd_q;
    assign mem_w     = mem_w_q;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed literal cases plus a random run checked every
// cycle against a transaction-level model (pending op + cycles-to-valid).
module tb_ex_stage;

`ifdef EX_STAGE_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = 4'd0;
    logic [15:0] rs_val = 16'h0, rt_val = 16'h0, imm = 16'h0, st_data = 16'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] result, rd;
    logic        mem_w;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    ex_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rs_val(rs_val), .rt_val(rt_val), .imm(imm), .st_data(st_data),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .rd(rd),
        .mem_w(mem_w)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: at most one op in the stage; m_left counts cycles until it shows.
    bit          m_pend = 1'b0;
    int          m_left = 0;
    logic [15:0] m_res, m_rd;
    logic        m_mw;

    function automatic bit m_valid();
        return m_pend && (m_left == 0);
    endfunction

    function automatic bit m_in_ready();
        return rst_n && (!m_pend || (m_valid() && out_ready));
    endfunction

    function automatic logic [15:0] ref_res(input logic [3:0] o, input logic [15:0] a,
                                            input logic [15:0] b, input logic [15:0] i);
        logic [31:0] p;
        p = {16'h0, a} * {16'h0, b};
        case (o)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << b[3:0];
            4'd6: return a >> b[3:0];
            4'd7: return MUL_EN ? p[15:0] : 16'h0;
            4'd8, 4'd9: return a + i;
            default: return 16'h0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] o, input logic [15:0] b);
        if (o == 4'd5 || o == 4'd6) return int'(b[3:0]) + 1;
        if (o == 4'd7 && MUL_EN) return 17;
        return 1;
    endfunction

    always @(posedge clk) begin : model
        bit rdy;
        rdy = m_in_ready();
        if (!rst_n) begin
            m_pend = 1'b0;
            m_left = 0;
        end else begin
            if (m_valid() && out_ready) m_pend = 1'b0;
            else if (m_pend && m_left > 0) m_left--;
            if (in_valid && rdy) begin
                m_pend = 1'b1;
                m_left = ref_lat(op, rt_val) - 1;
                m_res  = ref_res(op, rs_val, rt_val, imm);
                m_rd   = (op == 4'd9) ? st_data : rs_val;
                m_mw   = (op == 4'd9);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", in_ready, m_in_ready());
            chk("out_valid", out_valid, m_valid());
            if (m_valid()) begin
                chk("result", result, m_res);
                chk("rd", rd, m_rd);
                chk("mem_w", mem_w, m_mw);
            end else begin
                chk("mem_w_idle", mem_w, 1'b0);
            end
        end
    end

    // Presents one op for a single edge; caller guarantees the stage is ready.
    task automatic issue(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] i, input logic [15:0] sd);
        op = o; rs_val = a; rt_val = b; imm = i; st_data = sd; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rs_val = 16'hDEAD; rt_val = 16'hBEEF; imm = 16'h5A5A; st_data = 16'hA5A5;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_result", result, 16'h0);
        chk("rst_rd", rd, 16'h0);
        chk("rst_mem_w", mem_w, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // LD with one-cycle latency
        out_ready = 1'b1;
        issue(4'd8, 16'd10, 16'd0, 16'd13, 16'd0);
        @(negedge clk);
        chk("ld_valid", out_valid, 1'b1);
        chk("ld_result", result, 16'd23);
        chk("ld_rd", rd, 16'd10);
        chk("ld_mem_w", mem_w, 1'b0);
        @(posedge clk); #1;

        // LD address wrap
        issue(4'd8, 16'hFFFF, 16'd0, 16'd1, 16'd0);
        @(negedge clk);
        chk("ld_wrap", result, 16'h0000);
        @(posedge clk); #1;

        // ST held under back-pressure
        out_ready = 1'b0;
        issue(4'd9, 16'd20, 16'd0, 16'd3, 16'd10);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("st_valid", out_valid, 1'b1);
            chk("st_result", result, 16'd23);
            chk("st_rd", rd, 16'd10);
            chk("st_mem_w", mem_w, 1'b1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("st_gone", out_valid, 1'b0);
        chk("st_mem_w_gone", mem_w, 1'b0);
        @(posedge clk); #1;

        // ADD then SUB back to back
        op = 4'd0; rs_val = 16'd10; rt_val = 16'd20; in_valid = 1'b1;
        @(posedge clk); #1;
        op = 4'd1; rs_val = 16'd5; rt_val = 16'd6;
        @(negedge clk);
        chk("add_result", result, 16'd30);
        chk("b2b_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("sub_valid", out_valid, 1'b1);
        chk("sub_result", result, 16'hFFFF);
        @(posedge clk); #1;

        // Shifts
        issue(4'd5, 16'h0001, 16'd4, 16'd0, 16'd0);
        wait_valid(lat);
        chk("sll4_lat", 16'(lat), 16'd5);
        chk("sll4_result", result, 16'h0010);
        @(posedge clk); #1;
        issue(4'd5, 16'h1234, 16'd0, 16'd0, 16'd0);
        wait_valid(lat);
        chk("sll0_lat", 16'(lat), 16'd1);
        chk("sll0_result", result, 16'h1234);
        @(posedge clk); #1;

        // Multiply (or reserved when the multiplier is not built)
        issue(4'd7, 16'd300, 16'd300, 16'd0, 16'd0);
        wait_valid(lat);
        chk("mul_lat", 16'(lat), MUL_EN ? 16'd17 : 16'd1);
        chk("mul_result", result, MUL_EN ? 16'h5F90 : 16'h0000);
        @(posedge clk); #1;

        // Reset while the multiply is in flight
        out_ready = 1'b0;
        issue(4'd7, 16'd300, 16'd300, 16'd0, 16'd0);
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_in_ready", in_ready, 1'b1);
        chk("mrst_valid", out_valid, 1'b0);
        chk("mrst_result", result, 16'h0);
        chk("mrst_rd", rd, 16'h0);
        chk("mrst_mem_w", mem_w, 1'b0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("mrst_quiet", out_valid, 1'b0);
        end
        @(posedge clk); #1;

        // Random traffic; operands change every cycle, even mid-operation
        for (int k = 0; k < 3000; k++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            op        = 4'($urandom_range(0, 15));
            rs_val    = 16'($urandom);
            rt_val    = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
            imm       = 16'($urandom);
            st_data   = 16'($urandom);
            out_ready = ($urandom_range(0, 9) < 6);
            rst_n     = ($urandom_range(0, 199) != 0);
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (25) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset; ports clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on clk.
REQ-004 in_valid  input  1  upstream (decode) presents an operation.
REQ-005 in_ready  output  1  stage accepts; transfer when in_valid && in_ready at clk edge.
REQ-006 op  input  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 MUL, 8 LD, 9 ST, 10-15 reserved.
REQ-007 rs_val  input  16  first operand / base address.
REQ-008 rt_val  input  16  second operand / shift count (bits [3:0]).
REQ-009 imm  input  16  address offset for LD/ST.
REQ-010 st_data  input  16  store data for ST.
REQ-011 out_valid  output  1  result valid to the writeback/memory stage.
REQ-012 out_ready  input  1  downstream consumes; transfer when out_valid && out_ready.
REQ-013 result  output  16  ALU result or memory address.
REQ-014 rd  output  16  store data (ST) or rs_val passthrough (all other ops).
REQ-015 mem_w  output  1  memory write enable for the downstream stage.

Function
REQ-016 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-017 in_ready SHALL be 1 in IDLE, 1 in DONE when out_ready=1, otherwise 0.
REQ-018 Accepting a single-cycle op (0-4, 8, 9, reserved) SHALL enter DONE; out_valid=1 on the next cycle (latency 1).
REQ-019 ADD/SUB/AND/OR/XOR SHALL compute rs_val op rt_val modulo 2^16, no carry/overflow output.
REQ-020 LD and ST SHALL produce result = rs_val + imm modulo 2^16; address wrap-around (0xFFFF+1 = 0x0000) SHALL be silent.
REQ-021 mem_w SHALL be 1 only while out_valid=1 and the held op is ST; 0 otherwise.
REQ-022 Reserved ops SHALL produce result=0, rd=rs_val, mem_w=0.
REQ-023 SLL/SRL SHALL shift rs_val by rt_val[3:0] one bit per cycle in BUSY, zero-fill; count 0 SHALL go straight to DONE (latency 1); count n SHALL give latency n+1.
REQ-024 MUL SHALL use iterative shift-add, 16 BUSY cycles, result = low 16 bits of rs_val*rt_val; latency 17.
REQ-025 BUSY SHALL ignore in_valid (in_ready=0) and SHALL not be affected by out_ready.
REQ-026 DONE SHALL hold result, rd, mem_w, out_valid stable until out_ready=1.
REQ-027 In DONE with out_ready=1 and in_valid=1, the new op SHALL be accepted in the same cycle (back-to-back, throughput 1 for single-cycle ops).
REQ-028 In DONE with out_ready=1 and in_valid=0, the FSM SHALL return to IDLE and out_valid SHALL drop next cycle.
REQ-029 Inputs SHALL be captured at acceptance; later changes to op/operands SHALL not affect an in-flight op.

Reset
REQ-030 rst_n=0 at a clk edge SHALL force IDLE, out_valid=0, mem_w=0, result=0, rd=0, and clear all internal counters.
REQ-031 in_ready SHALL be 0 while rst_n=0.
REQ-032 Reset during BUSY or DONE SHALL discard the in-flight op without emitting it.

Configuration
REQ-033 Macro EX_STAGE_MUL_EN SHALL control the multiplier.
REQ-034 With EX_STAGE_MUL_EN defined, op 7 SHALL behave per REQ-024.
REQ-035 Without EX_STAGE_MUL_EN, op 7 SHALL be treated as reserved (REQ-022, latency 1) and the multiply datapath SHALL not be synthesized.

Verification
REQ-036 LD rs=10, imm=13, out_ready=1 -> out_valid 1 cycle later, result=23, mem_w=0, rd=10.
REQ-037 ST rs=20, imm=3, st_data=10, out_ready=0 for 3 cycles -> result=23, rd=10, mem_w=1 held stable 3 cycles; one transfer when out_ready=1.
REQ-038 ADD 10+20 then SUB 5-6 back-to-back, out_ready=1 -> results 30 then 0xFFFF on consecutive cycles, in_ready=1 throughout.
REQ-039 SLL rs=0x0001 rt=4 -> out_valid after 5 cycles, result=0x0010; in_ready=0 during BUSY; SLL rt=0 -> latency 1, result=rs.
REQ-040 MUL 300*300 (EX_STAGE_MUL_EN) -> latency 17, result=0x5F90; same stimulus without macro -> latency 1, result=0.
REQ-041 MUL accepted, rst_n=0 at cycle 8 -> out_valid never asserts, outputs 0, in_ready=1 the cycle after rst_n returns to 1.
